// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster pipeline.
package vga_timing_pkg;

  // Raster coordinate width; both axes must fit in 1024 positions.
  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1024;

  // Default 640x480@60 timing (25.175 MHz pixel clock).
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_BOTTOM  = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_TOP     = 33;

  // Tiny VGA Pmod bit positions on uo_out.
  localparam int UO_R1    = 0;
  localparam int UO_G1    = 1;
  localparam int UO_B1    = 2;
  localparam int UO_VSYNC = 3;
  localparam int UO_R0    = 4;
  localparam int UO_G0    = 5;
  localparam int UO_B0    = 6;
  localparam int UO_HSYNC = 7;

  // Positions per axis: visible + front porch + sync + back porch.
  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: position counter plus registered sync/visible decode.
// The decode registers are loaded from the next-state position so they
// always describe the position being presented, with no skew.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   DISPLAY  = DEF_H_DISPLAY,
  parameter int   FRONT    = DEF_H_FRONT,
  parameter int   SYNC     = DEF_H_SYNC,
  parameter int   BACK     = DEF_H_BACK,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               adv,
  output logic [COORD_W-1:0] pos,
  output logic               wrap,
  output logic               sync,
  output logic               visible
);

  localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam logic [COORD_W-1:0] LAST_C       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] DISP_C       = COORD_W'(DISPLAY);
  localparam logic [COORD_W-1:0] SYNC_FIRST_C = COORD_W'(DISPLAY + FRONT);
  localparam logic [COORD_W-1:0] SYNC_LAST_C  = COORD_W'(DISPLAY + FRONT + SYNC - 1);

  logic [COORD_W-1:0] pos_r;
  logic [COORD_W-1:0] pos_next_s;
  logic               at_last_s;
  logic               sync_r;
  logic               sync_next_s;
  logic               visible_r;
  logic               visible_next_s;

  // Next position and its sync/visible decode.
  always_comb begin
    pos_next_s     = pos_r;
    sync_next_s    = ~SYNC_POL;
    visible_next_s = 1'b0;
    at_last_s      = (pos_r == LAST_C);
    if (adv) begin
      if (at_last_s) begin
        pos_next_s = {COORD_W{1'b0}};
      end else begin
        pos_next_s = pos_r + COORD_W'(1);
      end
    end else begin
      pos_next_s = pos_r;
    end
    if ((pos_next_s >= SYNC_FIRST_C) && (pos_next_s <= SYNC_LAST_C)) begin
      sync_next_s = SYNC_POL;
    end else begin
      sync_next_s = ~SYNC_POL;
    end
    visible_next_s = (pos_next_s < DISP_C);
  end

  // Position and decode registers; everything holds while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_r     <= {COORD_W{1'b0}};
      sync_r    <= ~SYNC_POL;
      visible_r <= 1'b0;
    end else if (en) begin
      pos_r     <= pos_next_s;
      sync_r    <= sync_next_s;
      visible_r <= visible_next_s;
    end
  end

  assign pos     = pos_r;
  assign wrap    = adv & at_last_s;
  assign sync    = sync_r;
  assign visible = visible_r;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: coordinates, syncs, display enable,
// line/frame strobes and a frame counter for the pattern generators.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY  = DEF_H_DISPLAY,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_DISPLAY  = DEF_V_DISPLAY,
  parameter int   V_BOTTOM   = DEF_V_BOTTOM,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_TOP      = DEF_V_TOP,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   FRAME_W    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_no
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);

  if (H_TOTAL > COORD_MAX) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds coordinate range");
  end
  if (V_TOTAL > COORD_MAX) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds coordinate range");
  end

  logic               h_wrap_s;
  logic               v_wrap_s;
  logic               h_vis_s;
  logic               v_vis_s;
  logic               line_flag_r;
  logic               frame_flag_r;
  logic [FRAME_W-1:0] frame_no_r;

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .SYNC_POL(H_SYNC_POL)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .adv    (1'b1),
    .pos    (hpos),
    .wrap   (h_wrap_s),
    .sync   (hsync),
    .visible(h_vis_s)
  );

  // The vertical axis steps only when the line wraps, but its decode
  // registers still reload on every enabled pixel.
  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_BOTTOM),
    .SYNC    (V_SYNC),
    .BACK    (V_TOP),
    .SYNC_POL(V_SYNC_POL)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .adv    (h_wrap_s),
    .pos    (vpos),
    .wrap   (v_wrap_s),
    .sync   (vsync),
    .visible(v_vis_s)
  );

  // Strobe flags mark the pixel entered by a wrap; the frame counter
  // steps on the same edge that raises the frame flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_flag_r  <= 1'b0;
      frame_flag_r <= 1'b0;
      frame_no_r   <= {FRAME_W{1'b0}};
    end else if (en) begin
      line_flag_r  <= h_wrap_s;
      frame_flag_r <= v_wrap_s;
      if (v_wrap_s) begin
        frame_no_r <= frame_no_r + FRAME_W'(1);
      end
    end
  end

  // Both visibility bits are registers; post-reset both start low, so
  // the first (0,0) after reset is blanked.
  assign display_on  = h_vis_s & v_vis_s;
  // Gating with en limits each strobe to a single enabled pixel even
  // when the pipeline stalls on the first pixel of a line or frame.
  assign line_start  = line_flag_r & en;
  assign frame_start = frame_flag_r & en;
  assign frame_no    = frame_no_r;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the VGA pattern generators.
- Produces raster coordinates (hpos/vpos), sync pulses, display_on and a frame counter for a Tiny VGA Pmod pixel pipeline.
- All timing is parameterised; defaults are 640x480@60 with a 25.175 MHz pixel clock.
- Adds line_start/frame_start strobes and frame_no, so downstream pattern blocks need no private vsync edge detector.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines
- V_BOTTOM, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_TOP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level
- FRAME_W, 9, frame_no width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- en  in  1  pixel enable; tie to 1 when clk equals the pixel rate
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, H_SYNC_POL active
- vsync  out  1  vertical sync, V_SYNC_POL active
- display_on  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- line_start  out  1  one-cycle strobe, first pixel of each line
- frame_start  out  1  one-cycle strobe, first pixel of each frame
- frame_no  out  FRAME_W  frame counter

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - In reset: hpos=0, vpos=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, display_on=0, line_start=0, frame_start=0, frame_no=0.
- Derived totals: H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL analogous (525). Both must be at most 1024; elaboration-time check.
- Stall: registers advance only on edges with en=1. With en=0 every register holds.
- hpos: increments each enabled cycle; wraps H_TOTAL-1 -> 0.
- vpos: increments on the hpos wrap; wraps V_TOTAL-1 -> 0 when hpos also wraps.
- Coherence: all outputs are registered and describe the currently presented (hpos,vpos). Zero-cycle skew between coordinates and sync/display_on. Implement by decoding next-state counter values into the output registers.
- hsync active iff H_DISPLAY+H_FRONT <= hpos <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
- vsync active iff V_DISPLAY+V_BOTTOM <= vpos <= V_DISPLAY+V_BOTTOM+V_SYNC-1 (490..491), for the whole line including hblank.
- display_on:
  - First cycle after reset release presents (0,0) with display_on=0. This is the only blanked visible pixel.
  - After that, display_on=1 exactly when (hpos,vpos) is visible.
- Strobes:
  - line_start: internal flag set on every hpos wrap.
  - frame_start: internal flag set on the combined hpos+vpos wrap.
  - Each output is the flag ANDed with en, so it is high for exactly one en=1 cycle.
  - Neither strobe asserts for the post-reset (0,0).
- frame_no: increments at the same edge that sets frame_start; wraps 2^FRAME_W-1 -> 0.
- Reset mid-frame: next cycle matches the post-reset state; no partial strobes.

Decomposition:
- Shared package vga_timing_pkg:
  - default 640x480 timing constants
  - H_TOTAL/V_TOTAL derivation functions
  - coordinate width constant COORD_W=10
  - Tiny VGA Pmod uo_out bit-index constants
- One natural sub-module, vga_axis_counter, instantiated once per axis. It provides:
  - counter with advance input, wrap output
  - registered sync and visible decode from next-state value
  - parameters for display/front/sync/back lengths and polarity

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> hpos=0, vpos=0, hsync=1, vsync=1, display_on=0, strobes 0, frame_no=0.
- Line timing (defaults, en=1):
  - display_on 1->0 between hpos 639 and 640.
  - hsync falls at 656 and rises at 752.
  - hpos 799->0 with vpos +1 and line_start=1 for one cycle.
- Frame timing: vsync low exactly on vpos 490 and 491. At (799,524)->(0,0): frame_start=1 for one cycle and frame_no 0->1 on the same edge.
- Stall: toggle en 1/0 randomly -> coordinates advance only on en=1 cycles. Each strobe is high for one en=1 cycle only; sync/display_on stay coherent with the coordinates.
- Small parameters (H 8/2/2/2, V 4/1/1/1, FRAME_W=3), 9 frames -> frame_no sequence 0..7,0,1. Post-reset (0,0) gives no frame_start.
- Reset mid-frame: assert rst_n=0 at (300,200) -> next cycle equals reset state. After release, the first frame_start arrives after exactly H_TOTAL*V_TOTAL enabled cycles.
